fpu_sequencer: RTL
==================

// Module: fpu_sequencer
// PURPOSE
//  Bus master that runs one complete FPU operation per request over the FPU's byte-wide port.
//  Accepts a 32-bit Y, a 32-bit X and an op (divide or multiply). Issues the command/value
//  byte writes, starts the op, polls the busy bit, reads back the 4 result bytes and returns
//  the 32-bit result. Sits between the CPU/DMA side and the FPU as that port's only master.
// PARAMETERS
//  SETTLE_CYC   2     idle cycles after the start command before the first status poll
//  TIMEOUT_POLL 64    max status polls before the op is abandoned (>=1)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-high; clears all state
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer can accept (high only in IDLE)
//  req_op       in   1   0 = divide Y/X (cmd 3), 1 = multiply Y*X (cmd 4)
//  req_y        in   32  IEEE single operand Y (dividend)
//  req_x        in   32  IEEE single operand X (divisor)
//  rsp_valid    out  1   result valid; held until rsp_ready
//  rsp_ready    in   1   consumer accepts result
//  rsp_result   out  32  result word, MSB byte first as read from FPU
//  rsp_timeout  out  1   qualifies rsp_valid: op abandoned, rsp_result = 0
//  fpu_sel      out  1   FPU select, high exactly when fpu_read or fpu_write is high
//  fpu_addr     out  2   00 status, 01 result, 10 command, 11 value
//  fpu_read     out  1   read strobe
//  fpu_write    out  1   write strobe
//  fpu_wdata    out  8   command code or value byte
//  fpu_rdata    in   8   FPU read data (combinational from FPU, sampled in strobe cycle)
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 after reset deasserts; rsp_valid, rsp_timeout, fpu_sel,
//   fpu_read, fpu_write = 0; fpu_addr, fpu_wdata, rsp_result = 0; all counters 0.
//  Bus access: exactly 1 strobe cycle then 1 gap cycle with all strobes low.
//   The FPU advances its byte index on strobe fall and reacts to a command on strobe rise,
//   so strobes are never held 2 cycles or issued back to back.
//   fpu_addr and fpu_wdata are stable in the strobe cycle; they are 0 in gap cycles.
//  States and sequence (each write/read = strobe + gap):
//   IDLE    : req_valid&req_ready captures y, x, op -> CMD_Y.
//   CMD_Y   : write addr 10, data 1 -> VAL_Y.
//   VAL_Y   : 4 writes, addr 11, y[31:24], y[23:16], y[15:8], y[7:0] -> CMD_X.
//   CMD_X   : write addr 10, data 2 -> VAL_X (4 writes of x, same order) -> CMD_OP.
//   CMD_OP  : write addr 10, data 3 (div) or 4 (mul) -> SETTLE.
//   SETTLE  : SETTLE_CYC cycles with strobes low -> POLL.
//   POLL    : read addr 00. fpu_rdata[7]=0 -> READ. Otherwise poll count+1 and repeat.
//             If count reaches TIMEOUT_POLL -> RESP with rsp_timeout=1 and rsp_result=0.
//   READ    : 4 reads, addr 01. Bytes shift into rsp_result MSB first -> RESP.
//   RESP    : rsp_valid=1. rsp_valid&rsp_ready -> IDLE, and rsp_valid/rsp_timeout clear
//             next cycle.
//  Latency, accept to rsp_valid with first poll not busy:
//   22 (writes) + SETTLE_CYC + 2 (poll) + 8 (reads) cycles = 34 at default.
//  Captured operands are immune to req_* changes after accept. req_valid outside IDLE is
//   ignored (no accept).
//  Back-to-back: new accept no earlier than the cycle after the rsp handshake.
//  Every op begins with a set-Y command, so FPU byte indices resynchronise after any abort.
//  Reset mid-operation: immediate return to reset values. A partially written FPU operand
//   is harmless. No response is produced for the aborted request.
// TESTING
//  1 div: y=0x40C00000 (6.0), x=0x40000000 (2.0), op=0
//    -> exact bus trace 10:01, 11:40,C0,00,00, 10:02, 11:40,00,00,00, 10:03;
//       rsp_result=0x40400000, rsp_timeout=0.
//  2 mul: y=0x40400000 (3.0), x=0x40000000 (2.0), op=1
//    -> cmd 04 issued, rsp_result=0x40C00000.
//  3 FPU model busy for 5 polls -> exactly 6 status reads, then 4 result reads;
//    rsp_valid at cycle 34+10.
//  4 FPU busy stuck high, TIMEOUT_POLL=4 -> 4 polls, no result reads,
//    rsp_timeout=1, rsp_result=0.
//  5 rsp_ready low 10 cycles -> rsp_valid and rsp_result held stable, req_ready=0,
//    new req_valid ignored.
//  6 reset pulse during VAL_X, then a mul request 1.5*1.5 (0x3FC00000)
//    -> all strobes 0 during reset; result 0x40100000.
//  Checker on all tests: no strobe high 2 consecutive cycles; fpu_sel == fpu_read|fpu_write.

Source files
------------

// File: rtl/fpu_sequencer.sv
// Bus master that runs one FPU divide/multiply per request over the FPU's byte-wide port:
// loads Y and X, starts the op, polls busy, reads the 4-byte result and returns it.
module fpu_sequencer #(
  parameter int SETTLE_CYC   = 2,
  parameter int TIMEOUT_POLL = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_y,
  input  logic [31:0] req_x,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        fpu_sel,
  output logic [1:0]  fpu_addr,
  output logic        fpu_read,
  output logic        fpu_write,
  output logic [7:0]  fpu_wdata,
  input  logic [7:0]  fpu_rdata
);

  localparam int PW = $clog2(TIMEOUT_POLL + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] A_STATUS = 2'b00;
  localparam logic [1:0] A_RESULT = 2'b01;
  localparam logic [1:0] A_CMD    = 2'b10;
  localparam logic [1:0] A_VALUE  = 2'b11;

  localparam logic [7:0] C_SET_Y = 8'h01;
  localparam logic [7:0] C_SET_X = 8'h02;
  localparam logic [7:0] C_DIV   = 8'h03;
  localparam logic [7:0] C_MUL   = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_Y, S_VAL_Y, S_CMD_X, S_VAL_X, S_CMD_OP, S_SETTLE, S_POLL, S_READ, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            gap_q, gap_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic            busy_q, busy_d;
  logic            op_q, op_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     x_q, x_d;
  logic [31:0]     result_q, result_d;
  logic            timeout_q, timeout_d;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    poll_d      = poll_q;
    busy_d      = busy_q;
    op_d        = op_q;
    y_d         = y_q;
    x_d         = x_q;
    result_d    = result_q;
    timeout_d   = timeout_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
    fpu_read    = 1'b0;
    fpu_write   = 1'b0;
    fpu_addr    = 2'b00;
    fpu_wdata   = 8'h00;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        gap_d     = 1'b0;
        if (req_valid) begin
          y_d       = req_y;
          x_d       = req_x;
          op_d      = req_op;
          result_d  = '0;
          timeout_d = 1'b0;
          poll_d    = '0;
          cnt_d     = '0;
          state_d   = S_CMD_Y;
        end
      end
      S_CMD_Y: begin
        {fpu_write, fpu_addr, fpu_wdata} = {1'b1, A_CMD, C_SET_Y};
        gap_d = !gap_q;
        if (gap_q) state_d = S_VAL_Y;
      end
      S_VAL_Y: begin
        {fpu_write, fpu_addr, fpu_wdata} = {1'b1, A_VALUE, byte_of(y_q, cnt_q)};
        gap_d = !gap_q;
        if (gap_q) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_CMD_X;
        end
      end
      S_CMD_X: begin
        {fpu_write, fpu_addr, fpu_wdata} = {1'b1, A_CMD, C_SET_X};
        gap_d = !gap_q;
        if (gap_q) state_d = S_VAL_X;
      end
      S_VAL_X: begin
        {fpu_write, fpu_addr, fpu_wdata} = {1'b1, A_VALUE, byte_of(x_q, cnt_q)};
        gap_d = !gap_q;
        if (gap_q) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_CMD_OP;
        end
      end
      S_CMD_OP: begin
        {fpu_write, fpu_addr, fpu_wdata} = {1'b1, A_CMD, op_q ? C_MUL : C_DIV};
        gap_d = !gap_q;
        if (gap_q) begin
          settle_d = '0;
          state_d  = (SETTLE_CYC == 0) ? S_POLL : S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d = S_POLL;
      end
      S_POLL: begin
        {fpu_read, fpu_addr} = {1'b1, A_STATUS};
        gap_d = !gap_q;
        if (!gap_q) begin
          busy_d = fpu_rdata[7];
          if (fpu_rdata[7]) poll_d = poll_q + PW'(1);
        end else if (!busy_q) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else if (poll_q == PW'(TIMEOUT_POLL)) begin
          // Abandoned op: result stays at the zero loaded on accept.
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_READ: begin
        {fpu_read, fpu_addr} = {1'b1, A_RESULT};
        gap_d = !gap_q;
        if (!gap_q) begin
          result_d = {result_q[23:0], fpu_rdata};
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_timeout = timeout_q;
        if (rsp_ready) begin
          timeout_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes last one cycle; the following cycle is a quiet gap with address and data at 0.
    if (gap_q) begin
      fpu_read  = 1'b0;
      fpu_write = 1'b0;
      fpu_addr  = 2'b00;
      fpu_wdata = 8'h00;
    end
  end

  assign fpu_sel    = fpu_read | fpu_write;
  assign rsp_result = result_q;

  // NOTE: state uses non-blocking assignments; operands are reset too because a reset must clear every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gap_q     <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
      poll_q    <= '0;
      busy_q    <= 1'b0;
      op_q      <= 1'b0;
      y_q       <= '0;
      x_q       <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      poll_q    <= poll_d;
      busy_q    <= busy_d;
      op_q      <= op_d;
      y_q       <= y_d;
      x_q       <= x_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
